// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: MDU stall, branch flush, load-use stall, perf counters
//
// Purpose:
//   Decodes pipeline enables/flushes from the EX/ID hazard inputs and a small
//   RUN/BUSY/DONE FSM that holds the front of the pipeline for the full
//   multiply/divide latency. Two saturating counters track stalled cycles and
//   branch flush events.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_rs1, id_rs2                  source registers of the ID instruction
//   id_use_rs1, id_use_rs2          ID instruction actually reads that source
//   ex_rd, ex_mem_read              EX destination register, EX is a load
//   ex_branch_taken                 EX redirects the PC
//   ex_mdu_start, ex_mdu_is_div     EX is a mul/div (1 = divide)
//   clr_cnt                         synchronous clear of both counters
//   pc_en, ifid_en, idex_en         pipeline register enables
//   ifid_flush, idex_flush,
//   exmem_flush                     pipeline register flushes (override enables)
//   mdu_busy, mdu_done              MDU stall in progress / result written
//   stall_cycles, flush_events      saturating performance counters
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 34,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_start,
    input  logic             ex_mdu_is_div,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The trigger cycle is itself a stall cycle, and BUSY runs cnt down to 0
    // inclusive, so loading LAT-2 gives exactly LAT stalled cycles.
    localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 2);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 2);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_nxt;

    logic       w_trigger;
    logic       w_load_use;
    logic       w_branch_flush;

    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    assign w_trigger  = (r_state == ST_RUN) && ex_mdu_start;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        idex_en        = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        exmem_flush    = 1'b0;
        mdu_busy       = 1'b0;
        mdu_done       = 1'b0;
        w_branch_flush = 1'b0;

        if (r_state == ST_BUSY) begin
            // Branch and load-use are ignored while the MDU holds the pipe.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            mdu_busy    = 1'b1;
            if (r_cnt == 6'd0) begin
                w_state_nxt = ST_DONE;
            end else begin
                w_cnt_nxt = r_cnt - 6'd1;
            end
        end else if (w_trigger) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            mdu_busy    = 1'b1;
            w_cnt_nxt   = ex_mdu_is_div ? DIV_LOAD : MUL_LOAD;
            w_state_nxt = ST_BUSY;
        end else begin
            // RUN without trigger, or DONE (where ex_mdu_start is ignored).
            if (r_state == ST_DONE) begin
                mdu_done    = 1'b1;
                w_state_nxt = ST_RUN;
            end
            if (ex_branch_taken) begin
                ifid_flush     = 1'b1;
                idex_flush     = 1'b1;
                w_branch_flush = 1'b1;
            end else if (w_load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else if (clr_cnt) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!pc_en && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_branch_flush && (r_flush_events != {CNT_W{1'b1}})) begin
                r_flush_events <= r_flush_events + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a cycle-level reference model
module tb_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 34;
    localparam int CNT_MAX = 65535;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        ex_mdu_start;
    logic        ex_mdu_is_div;
    logic        clr_cnt;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        mdu_busy;
    logic        mdu_done;
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;

    hazard_ctrl #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start   (ex_mdu_start),
        .ex_mdu_is_div  (ex_mdu_is_div),
        .clr_cnt        (clr_cnt),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .idex_en        (idex_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_flush    (exmem_flush),
        .mdu_busy       (mdu_busy),
        .mdu_done       (mdu_done),
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining MDU stall cycles after the current one, and
    // whether the current cycle is the result-write cycle.
    int m_left = 0;
    bit m_done = 1'b0;
    int m_sc   = 0;
    int m_fe   = 0;
    int busy_seen = 0;

    function automatic logic [7:0] obs_vec();
        return {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, mdu_busy, mdu_done};
    endfunction

    function automatic bit mdu_stalling();
        return (m_left > 0) || (ex_mdu_start && !m_done);
    endfunction

    function automatic bit load_use();
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    // Expected {pc_en,ifid_en,idex_en,ifid_flush,idex_flush,exmem_flush,busy,done}
    function automatic logic [7:0] exp_vec();
        logic [7:0] e;
        if (mdu_stalling()) begin
            e = 8'b000_001_1_0;
        end else begin
            e = {3'b111, 3'b000, 1'b0, m_done};
            if (ex_branch_taken) begin
                e[4] = 1'b1;
                e[3] = 1'b1;
            end else if (load_use()) begin
                e[7] = 1'b0;
                e[6] = 1'b0;
                e[3] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        ex_mdu_start = 1'b0; ex_mdu_is_div = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic model_reset();
        m_left = 0; m_done = 1'b0; m_sc = 0; m_fe = 0;
    endtask

    // One clock: check outputs mid-cycle, advance the model at the edge,
    // then check the counters just after the edge.
    task automatic step();
        logic [7:0] e;
        bit br;
        #1;
        e  = exp_vec();
        br = !mdu_stalling() && ex_branch_taken;
        check("outputs", 32'(obs_vec()), 32'(e));
        if (mdu_busy) busy_seen++;
        @(posedge clk);
        if (clr_cnt) begin
            m_sc = 0;
            m_fe = 0;
        end else begin
            if (!e[7] && m_sc < CNT_MAX) m_sc++;
            if (br && m_fe < CNT_MAX) m_fe++;
        end
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (ex_mdu_start && !m_done) begin
            m_left = (ex_mdu_is_div ? DIV_LAT : MUL_LAT) - 1;
        end else begin
            m_done = 1'b0;
        end
        #1;
        check("stall_cycles", 32'(stall_cycles), 32'(m_sc));
        check("flush_events", 32'(flush_events), 32'(m_fe));
    endtask

    initial begin
        int sc0;
        quiet();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(obs_vec()), 32'(8'b111_000_0_0));
        check("reset_stall", 32'(stall_cycles), 32'd0);
        check("reset_flush", 32'(flush_events), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Load-use on rs2
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_use_rs2 = 1'b1; id_rs2 = 5'd5;
        step();
        check("lu_stall_count", 32'(stall_cycles), 32'd1);
        quiet();
        // Load into x0 never stalls
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_use_rs1 = 1'b1; id_rs1 = 5'd0;
        step();
        // Branch plus load-use in the same cycle
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_use_rs1 = 1'b1; id_rs1 = 5'd7; ex_branch_taken = 1'b1;
        step();
        check("br_lu_flush_events", 32'(flush_events), 32'd1);
        check("br_lu_stall_unchanged", 32'(stall_cycles), 32'd1);
        quiet();

        // Multiply held through the stall and the DONE cycle
        sc0 = int'(stall_cycles);
        ex_mdu_start = 1'b1; ex_mdu_is_div = 1'b0;
        repeat (MUL_LAT + 1) step();
        check("mul_stall_total", 32'(int'(stall_cycles) - sc0), 32'(MUL_LAT));
        quiet();
        step();

        // Divide with branch pulses during BUSY
        busy_seen = 0;
        sc0 = int'(stall_cycles);
        ex_mdu_start = 1'b1; ex_mdu_is_div = 1'b1;
        step();
        ex_mdu_start = 1'b0;
        for (int i = 1; i < DIV_LAT; i++) begin
            ex_branch_taken = (i % 5 == 0);
            step();
        end
        ex_branch_taken = 1'b0;
        step();
        check("div_busy_cycles", 32'(busy_seen), 32'(DIV_LAT));
        check("div_stall_total", 32'(int'(stall_cycles) - sc0), 32'(DIV_LAT));
        step();

        // Reset asserted at the 10th cycle of a divide
        ex_mdu_start = 1'b1; ex_mdu_is_div = 1'b1;
        repeat (9) step();
        quiet();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid_div_outputs", 32'(obs_vec()), 32'(8'b111_000_0_0));
        check("rst_mid_div_stall", 32'(stall_cycles), 32'd0);
        check("rst_mid_div_flush", 32'(flush_events), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom);
            id_use_rs2      = 1'($urandom);
            ex_rd           = 5'($urandom_range(0, 3));
            ex_mem_read     = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            ex_mdu_start    = ($urandom_range(0, 15) == 0);
            ex_mdu_is_div   = ($urandom_range(0, 3) == 0);
            clr_cnt         = ($urandom_range(0, 199) == 0);
            step();
        end
        quiet();
        step();

        // Drive the stall counter into saturation, then clear during a stall
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_use_rs1 = 1'b1; id_rs1 = 5'd9;
        repeat (CNT_MAX + 4) step();
        check("stall_saturated", 32'(stall_cycles), 32'hFFFF);
        clr_cnt = 1'b1;
        step();
        check("clr_during_stall", 32'(stall_cycles), 32'd0);
        quiet();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be: MUL_LAT, 4, multiply stall length in cycles (>=2); DIV_LAT, 34, divide stall length in cycles (>=2); CNT_W, 16, width of each performance counter.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 id_rs1, id_rs2  in  5 each  source register numbers of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  the ID instruction reads that source.
REQ-007 ex_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_mem_read  in  1  the EX instruction is a load.
REQ-009 ex_branch_taken  in  1  the EX instruction redirects the PC.
REQ-010 ex_mdu_start  in  1  the EX instruction is a mul/div.
REQ-011 ex_mdu_is_div  in  1  qualifies ex_mdu_start: 1 is divide, 0 is multiply.
REQ-012 clr_cnt  in  1  synchronous clear of both performance counters.
REQ-013 pc_en, ifid_en, idex_en  out  1 each  enables for the PC, IF/ID and ID/EX registers.
REQ-014 ifid_flush, idex_flush, exmem_flush  out  1 each  flushes for the IF/ID, ID/EX and EX/MEM registers; each flush overrides the matching enable in the pipeline register.
REQ-015 mdu_busy, mdu_done  out  1 each  MDU stall is in progress; MDU result is written this cycle.
REQ-016 stall_cycles, flush_events  out  CNT_W each  saturating performance counters.

Function
REQ-017 The FSM SHALL have the states RUN, BUSY and DONE, plus a down-counter cnt that is 6 bits wide.
REQ-018 All enable and flush outputs SHALL be combinational from state and inputs; their default is all enables=1 and all flushes=0.
REQ-019 The MDU trigger SHALL be state==RUN and ex_mdu_start=1; it has highest priority.
REQ-020 On an MDU trigger: pc_en=ifid_en=idex_en=0 and exmem_flush=1; cnt loads (DIV_LAT or MUL_LAT)-2; next state is BUSY.
REQ-021 In BUSY: the same stall outputs as REQ-020; cnt decrements; when cnt==0, next state is DONE.
REQ-022 The total stall SHALL be exactly LAT cycles, counting the trigger cycle.
REQ-023 In DONE: default outputs, mdu_done=1, ex_mdu_start ignored; next state is RUN.
REQ-024 mdu_busy SHALL be 1 on the trigger cycle and in BUSY, and 0 otherwise.
REQ-025 Branch: in RUN with no MDU trigger and ex_branch_taken=1, the outputs SHALL be ifid_flush=1 and idex_flush=1, with all enables=1.
REQ-026 Load-use: in RUN with no MDU trigger and no branch, ex_mem_read=1, ex_rd!=0, and (id_use_rs1 and id_rs1==ex_rd, or id_use_rs2 and id_rs2==ex_rd): the outputs SHALL be pc_en=0, ifid_en=0, idex_flush=1.
REQ-027 Priority SHALL be MDU trigger > branch > load-use; ex_branch_taken and load-use are ignored in BUSY.
REQ-028 In DONE, branch and load-use SHALL be evaluated as in RUN.
REQ-029 stall_cycles SHALL increment in each cycle with pc_en=0, saturating at all-ones.
REQ-030 flush_events SHALL increment in each cycle where REQ-025 applies, saturating at all-ones.
REQ-031 clr_cnt SHALL zero both counters on the next edge, with priority over increment.
REQ-032 ex_rd==0 SHALL never cause a load-use stall.

Reset
REQ-033 On rst_n=0 (asynchronous, at any time including mid-BUSY): state=RUN, cnt=0, stall_cycles=0, flush_events=0.
REQ-034 During and after reset, outputs SHALL follow RUN-state decoding; with quiet inputs they are all enables=1, all flushes=0, mdu_busy=0, mdu_done=0.

Verification
REQ-035 Load-use: ex_mem_read=1, ex_rd=5, id_use_rs2=1, id_rs2=5 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 for that cycle; stall_cycles goes 0->1.
REQ-036 Branch plus load-use in the same cycle -> ifid_flush=1, idex_flush=1, pc_en=1; flush_events=1; stall_cycles unchanged.
REQ-037 Multiply: ex_mdu_start=1, ex_mdu_is_div=0 held -> 4 cycles with pc_en=0 and exmem_flush=1, then 1 cycle with mdu_done=1 and all enables=1, then RUN; stall_cycles=4.
REQ-038 Divide with DIV_LAT=34 -> exactly 34 stall cycles, with mdu_busy high for 34 cycles, and ex_branch_taken pulses during BUSY ignored.
REQ-039 rst_n asserted at the 10th cycle of a divide -> outputs are immediately at RUN defaults and counters are 0, with no mdu_done pulse.
REQ-040 Counters preloaded by forcing 65535 stall cycles -> stall_cycles holds 0xFFFF; clr_cnt=1 together with a stall -> 0 on the next edge.
